// File: rtl/wb_dual_master_arbiter.sv
// Two-master, one-slave Wishbone classic arbiter with round-robin
// fairness, cycle locking and a per-access ack timeout.
module wb_dual_master_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    m0_cyc_i,
    input  logic                    m0_stb_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic [DATA_WIDTH-1:0]   m0_data_i,
    output logic [DATA_WIDTH-1:0]   m0_data_o,
    output logic                    m0_ack_o,
    output logic                    m0_err_o,
    input  logic                    m1_cyc_i,
    input  logic                    m1_stb_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic [DATA_WIDTH-1:0]   m1_data_i,
    output logic [DATA_WIDTH-1:0]   m1_data_o,
    output logic                    m1_ack_o,
    output logic                    m1_err_o,
    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    output logic                    s_we_o,
    output logic [DATA_WIDTH/8-1:0] s_sel_o,
    output logic [ADDR_WIDTH-1:0]   s_addr_o,
    output logic [DATA_WIDTH-1:0]   s_data_o,
    input  logic [DATA_WIDTH-1:0]   s_data_i,
    input  logic                    s_ack_i,
    output logic [1:0]              grant_o,
    output logic                    timeout_o
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] OWN0 = 2'b01;
    localparam logic [1:0] OWN1 = 2'b10;

    logic [1:0]    state_q, state_d, arb_state;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req0, req1, own0, own1, stb_raw, abort;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;
    assign own0 = (state_q == OWN0);
    assign own1 = (state_q == OWN1);

    // On a tie the master that was not granted last wins.
    always_comb begin
        arb_state = IDLE;
        if (req0 && (!req1 || last_q)) begin
            arb_state = OWN0;
        end else if (req1) begin
            arb_state = OWN1;
        end
    end

    assign stb_raw = (own0 & m0_stb_i) | (own1 & m1_stb_i);

    assign abort = (TIMEOUT_CYCLES != 0) && stb_raw && !s_ack_i &&
                   (cnt_q == CW'(TIMEOUT_CYCLES));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: state_d = arb_state;
            OWN0: begin
                if (abort)          state_d = IDLE;
                else if (!m0_cyc_i) state_d = arb_state;
            end
            OWN1: begin
                if (abort)          state_d = IDLE;
                else if (!m1_cyc_i) state_d = arb_state;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (state_d != state_q) begin
            if (state_d == OWN0) last_d = 1'b0;
            if (state_d == OWN1) last_d = 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (TIMEOUT_CYCLES == 0 || state_d != state_q || s_ack_i || !stb_raw) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_addr_o = '0;
        s_data_o = '0;
        if (own0) begin
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i;
            s_we_o   = m0_we_i;
            s_sel_o  = m0_sel_i;
            s_addr_o = m0_addr_i;
            s_data_o = m0_data_i;
        end else if (own1) begin
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i;
            s_we_o   = m1_we_i;
            s_sel_o  = m1_sel_i;
            s_addr_o = m1_addr_i;
            s_data_o = m1_data_i;
        end
        // Abandon the stuck access on the slave side.
        if (abort) begin
            s_cyc_o = 1'b0;
            s_stb_o = 1'b0;
        end
    end

    assign m0_data_o = s_data_i;
    assign m1_data_o = s_data_i;
    assign m0_ack_o  = s_ack_i & own0;
    assign m1_ack_o  = s_ack_i & own1;
    assign m0_err_o  = abort & own0;
    assign m1_err_o  = abort & own1;
    assign timeout_o = abort;
    assign grant_o   = state_q;

endmodule

// File: tb/tb_wb_dual_master_arbiter.sv
// Directed bench for wb_dual_master_arbiter: DUT a has a 4-cycle
// timeout, DUT b has the timeout disabled; both see the same stimulus.
module tb_wb_dual_master_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [3:0]  m0_sel, m1_sel;
    logic [31:0] m0_addr, m1_addr, m0_wd, m1_wd, s_rd;
    logic        s_ack;

    logic [31:0] a_m0_rd, a_m1_rd, a_s_addr, a_s_wd;
    logic        a_m0_ack, a_m1_ack, a_m0_err, a_m1_err;
    logic        a_s_cyc, a_s_stb, a_s_we, a_to;
    logic [3:0]  a_s_sel;
    logic [1:0]  a_grant;

    logic [31:0] b_m0_rd, b_m1_rd, b_s_addr, b_s_wd;
    logic        b_m0_ack, b_m1_ack, b_m0_err, b_m1_err;
    logic        b_s_cyc, b_s_stb, b_s_we, b_to;
    logic [3:0]  b_s_sel;
    logic [1:0]  b_grant;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_dual_master_arbiter #(.TIMEOUT_CYCLES(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we),
        .m0_sel_i(m0_sel), .m0_addr_i(m0_addr), .m0_data_i(m0_wd),
        .m0_data_o(a_m0_rd), .m0_ack_o(a_m0_ack), .m0_err_o(a_m0_err),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we),
        .m1_sel_i(m1_sel), .m1_addr_i(m1_addr), .m1_data_i(m1_wd),
        .m1_data_o(a_m1_rd), .m1_ack_o(a_m1_ack), .m1_err_o(a_m1_err),
        .s_cyc_o(a_s_cyc), .s_stb_o(a_s_stb), .s_we_o(a_s_we),
        .s_sel_o(a_s_sel), .s_addr_o(a_s_addr), .s_data_o(a_s_wd),
        .s_data_i(s_rd), .s_ack_i(s_ack),
        .grant_o(a_grant), .timeout_o(a_to)
    );

    wb_dual_master_arbiter #(.TIMEOUT_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we),
        .m0_sel_i(m0_sel), .m0_addr_i(m0_addr), .m0_data_i(m0_wd),
        .m0_data_o(b_m0_rd), .m0_ack_o(b_m0_ack), .m0_err_o(b_m0_err),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we),
        .m1_sel_i(m1_sel), .m1_addr_i(m1_addr), .m1_data_i(m1_wd),
        .m1_data_o(b_m1_rd), .m1_ack_o(b_m1_ack), .m1_err_o(b_m1_err),
        .s_cyc_o(b_s_cyc), .s_stb_o(b_s_stb), .s_we_o(b_s_we),
        .s_sel_o(b_s_sel), .s_addr_o(b_s_addr), .s_data_o(b_s_wd),
        .s_data_i(s_rd), .s_ack_i(s_ack),
        .grant_o(b_grant), .timeout_o(b_to)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic saw_err, bad_grant;
        rst_n = 1'b0;
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 4'hf;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 4'hf;
        m0_addr = 0; m1_addr = 0; m0_wd = 32'h0A0A0A0A; m1_wd = 32'h1B1B1B1B;
        s_rd = 0; s_ack = 0;
        tick(); tick();
        chk("rst_grant", 32'(a_grant), 0);
        chk("rst_cyc", 32'(a_s_cyc), 0);
        chk("rst_addr", a_s_addr, 0);

        // single master read
        rst_n = 1'b1;
        tick();
        m0_cyc = 1; m0_stb = 1; m0_addr = 32'h100;
        #1 chk("sm_idle_grant", 32'(a_grant), 0);
        tick();
        #1 chk("sm_grant", 32'(a_grant), 32'h1);
        chk("sm_s_addr", a_s_addr, 32'h100);
        chk("sm_s_cyc", 32'(a_s_cyc), 1);
        tick();
        #1 chk("sm_ack_early", 32'(a_m0_ack), 0);
        tick();
        s_ack = 1; s_rd = 32'hDEADBEEF;
        #1 chk("sm_ack", 32'(a_m0_ack), 1);
        chk("sm_data", a_m0_rd, 32'hDEADBEEF);
        chk("sm_m1_ack", 32'(a_m1_ack), 0);
        tick();
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        #1 chk("sm_ack_once", 32'(a_m0_ack), 0);
        tick();
        #1 chk("sm_idle", 32'(a_grant), 0);

        // contention from reset release
        rst_n = 1'b0;
        m0_cyc = 1; m0_stb = 1; m0_addr = 32'h200;
        m1_cyc = 1; m1_stb = 1; m1_addr = 32'h300;
        tick();
        rst_n = 1'b1;
        tick();
        s_ack = 1;
        #1 chk("ct_g1", 32'(a_grant), 32'h1);
        chk("ct_a1", a_s_addr, 32'h200);
        chk("ct_ack1", {a_m1_ack, a_m0_ack}, 32'h1);
        tick();
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        #1 chk("ct_rel0", 32'(a_grant), 32'h1);
        tick();
        m0_cyc = 1; m0_stb = 1; s_ack = 1;
        #1 chk("ct_g2", 32'(a_grant), 32'h2);
        chk("ct_a2", a_s_addr, 32'h300);
        chk("ct_ack2", {a_m1_ack, a_m0_ack}, 32'h2);
        tick();
        s_ack = 0; m1_cyc = 0; m1_stb = 0;
        #1 chk("ct_rel1", 32'(a_grant), 32'h2);
        tick();
        m1_cyc = 1; m1_stb = 1; s_ack = 1;
        #1 chk("ct_g3", 32'(a_grant), 32'h1);
        tick();
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        tick();
        s_ack = 1;
        #1 chk("ct_g4", 32'(a_grant), 32'h2);
        tick();
        s_ack = 0; m1_cyc = 0; m1_stb = 0;
        tick();
        #1 chk("ct_idle", 32'(a_grant), 0);

        // locked cycle: m1 three strobes while m0 waits
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_addr = 32'h10;
        m0_addr = 32'h400;
        tick();
        m0_cyc = 1; m0_stb = 1; s_ack = 1;
        #1 chk("lk_g1", 32'(a_grant), 32'h2);
        chk("lk_we1", 32'(a_s_we), 1);
        chk("lk_a1", a_s_addr, 32'h10);
        tick();
        m1_stb = 0; s_ack = 0;
        #1 chk("lk_gap", {30'(a_grant), a_s_stb}, 32'h4);
        tick();
        m1_stb = 1; m1_we = 0; m1_addr = 32'h14; s_ack = 1; s_rd = 32'h1234;
        #1 chk("lk_a2", a_s_addr, 32'h14);
        chk("lk_rd2", a_m1_rd, 32'h1234);
        chk("lk_m0ack", 32'(a_m0_ack), 0);
        tick();
        m1_we = 1; m1_addr = 32'h18;
        #1 chk("lk_a3", a_s_addr, 32'h18);
        chk("lk_g3", 32'(a_grant), 32'h2);
        tick();
        m1_cyc = 0; m1_stb = 0; m1_we = 0; s_ack = 0;
        #1 chk("lk_rel", 32'(a_grant), 32'h2);
        tick();
        #1 chk("lk_m0g", 32'(a_grant), 32'h1);
        chk("lk_m0a", a_s_addr, 32'h400);
        m0_cyc = 0; m0_stb = 0;
        tick();

        // timeout with T=4, no ack
        m0_cyc = 1; m0_stb = 1; m0_addr = 32'h500;
        for (int i = 1; i <= 4; i++) begin
            tick();
            #1 chk("to_wait", {a_s_cyc, a_to, a_m0_err}, 32'h4);
        end
        tick();
        #1 chk("to_err", {a_s_cyc, a_s_stb, a_to, a_m0_err}, 32'h3);
        chk("to_m1err", 32'(a_m1_err), 0);
        chk("to_b_noerr", 32'(b_m0_err), 0);
        m0_cyc = 0; m0_stb = 0;
        tick();
        #1 chk("to_idle", {30'(a_grant), a_to}, 0);

        // timeout race: ack on the terminal cycle wins
        m0_cyc = 1; m0_stb = 1;
        for (int i = 1; i <= 4; i++) tick();
        tick();
        s_ack = 1;
        #1 chk("tr_ack", {a_s_cyc, a_m0_ack, a_to, a_m0_err}, 32'hC);
        tick();
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        tick();

        // async reset while m1 owns with strobe
        m1_cyc = 1; m1_stb = 1;
        tick();
        #1 chk("ar_own", {30'(a_grant), a_s_stb}, 32'h5);
        #2 rst_n = 1'b0;
        #1 chk("ar_drop", {30'(a_grant), a_s_cyc, a_s_stb}, 0);
        m0_cyc = 1; m0_stb = 1;
        tick();
        rst_n = 1'b1;
        tick();
        #1 chk("ar_tie", 32'(a_grant), 32'h1);
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        tick(); tick();

        // timeout disabled: 1000 cycles without ack on DUT b
        m0_cyc = 1; m0_stb = 1;
        saw_err = 0; bad_grant = 0;
        tick();
        for (int i = 0; i < 1000; i++) begin
            #1;
            if (b_m0_err || b_to) saw_err = 1;
            if (b_grant != 2'b01) bad_grant = 1;
            tick();
        end
        chk("t0_noerr", 32'(saw_err), 0);
        chk("t0_hold", 32'(bad_grant), 0);
        s_ack = 1;
        #1 chk("t0_ack", {b_grant, b_m0_ack, b_m0_err}, 32'h6);
        tick();
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        tick();
        #1 chk("t0_idle", 32'(b_grant), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_dual_master_arbiter.md
# wb_dual_master_arbiter

Two-master, one-slave Wishbone (classic) arbiter that shares the single `core_*` memory port between two requesters. Typical use: a core with separate instruction and data buses, or a core bus plus a debug/loader master, driving one Controller memory port. It has round-robin fairness, bus-cycle locking and a per-access ack timeout that returns an error instead of hanging the core.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, address width.
- `DATA_WIDTH`, 32, data width; the select width is `DATA_WIDTH/8`.
- `TIMEOUT_CYCLES`, 255, maximum cycles of `s_stb_o` without `s_ack_i` before abort. 0 disables the timeout. Counter width is `$clog2(TIMEOUT_CYCLES+1)`.

Ports (x = 0,1):
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mx_cyc_i` in 1: master x bus cycle.
- `mx_stb_i` in 1: master x strobe.
- `mx_we_i` in 1: master x write.
- `mx_sel_i` in DATA_WIDTH/8: master x byte selects.
- `mx_addr_i` in ADDR_WIDTH: master x address.
- `mx_data_i` in DATA_WIDTH: master x write data.
- `mx_data_o` out DATA_WIDTH: read data, `s_data_i` broadcast to both masters.
- `mx_ack_o` out 1: ack, routed to the granted master only.
- `mx_err_o` out 1: one-cycle timeout error pulse to the granted master.
- `s_cyc_o`, `s_stb_o`, `s_we_o` out 1: slave-side cycle, strobe and write.
- `s_sel_o` out DATA_WIDTH/8: slave-side byte selects.
- `s_addr_o` out ADDR_WIDTH: slave-side address.
- `s_data_o` out DATA_WIDTH: slave-side write data.
- `s_data_i` in DATA_WIDTH: slave read data.
- `s_ack_i` in 1: slave ack.
- `grant_o` out 2: one-hot current owner; `2'b00` when idle.
- `timeout_o` out 1: one-cycle pulse on any abort, for debug.

## Operation
- State machine states: IDLE, OWN0, OWN1.
- Request: `reqx = mx_cyc_i & mx_stb_i`.
- Pointer `last` is a 1-bit register recording the most recently granted master.

Arbitration (evaluated in IDLE, and in OWNx on the release cycle):
- Only one master requesting: it wins.
- Both requesting: the master not equal to `last` wins.
- Neither requesting: go to IDLE.
- The winner's state is entered on the next edge, and `last` is updated on that same edge.

Ownership:
- OWNx holds while `mx_cyc_i` = 1. This covers multiple strobes within one cycle and read-modify-write sequences.
- The other master's requests are ignored while OWNx holds.
- Release occurs on the cycle `mx_cyc_i` = 0. Arbitration runs in that same cycle, so the next owner can be granted without an IDLE bubble.

Muxing (combinational from state):
- In OWNx, all `s_*` outputs equal master x's inputs.
- In IDLE, all `s_*` outputs are 0.
- `mx_ack_o = s_ack_i & OWNx`.
- An ack arriving in IDLE is dropped.

Timeout:
- The counter increments each OWNx cycle with `s_stb_o` = 1 and `s_ack_i` = 0.
- It clears on `s_ack_i`, on `s_stb_o` = 0, and on any state change.
- When the counter equals `TIMEOUT_CYCLES` and `s_ack_i` = 0, that cycle:
  - `mx_err_o` = 1 and `timeout_o` = 1.
  - `s_cyc_o` and `s_stb_o` are forced to 0.
  - Next state is IDLE.
- `s_ack_i` on the terminal cycle wins: normal ack, no error.
- A master still holding `cyc` after the error is re-arbitrated normally.

## Timing
- Reset values: state IDLE, `last` = 1 (so master 0 wins the first tie), counter 0, every output 0.
- Reset mid-cycle drops `s_cyc_o` and `s_stb_o` immediately, because reset is asynchronous and the outputs are decoded from state.
- Grant latency: a request seen at edge N (state IDLE) is driven on the slave from edge N+1.
- The data path adds zero latency: `s_ack_i` reaches `mx_ack_o` in the same cycle.
- Back-to-back owners: m0 drops `cyc` in cycle N while m1 is requesting, so m1 is on the slave from N+1.
- Simultaneous requests at reset exit: m0 is granted first, then m1, and they alternate while both keep requesting.
- Timeout with `TIMEOUT_CYCLES` = T: with stb held and no ack, the error asserts in the (T+1)-th strobe cycle.

## Test plan
- Single master: m0 reads 0x100, slave acks 2 cycles after strobe with 0xDEADBEEF.
  - Required: `grant_o` = 01 one cycle after request; `m0_ack_o` for exactly 1 cycle; `m0_data_o` = 0xDEADBEEF; `m1_ack_o` stays 0.
- Contention: m0 and m1 both request at reset release, each doing single-beat accesses and re-requesting immediately.
  - Required: grant order m0, m1, m0, m1; no IDLE cycle between owners.
- Lock: m1 holds `cyc` across 3 strobes (write 0x10, read 0x14, write 0x18) while m0 requests throughout.
  - Required: m0 is not granted until the cycle after `m1_cyc_i` falls.
- Timeout: `TIMEOUT_CYCLES` = 4, m0 strobes and the slave never acks.
  - Required: `m0_err_o` and `timeout_o` pulse 1 cycle in the 5th strobe cycle; `s_cyc_o` = 0 that cycle; `grant_o` = 00 next cycle.
  - Repeat with the ack on the 5th cycle: required normal ack, no error.
- Async reset while OWN1 with `s_stb_o` = 1: `s_cyc_o`, `s_stb_o` and `grant_o` go to 0 before the next clock edge. After release, m0 wins the first tie.
- `TIMEOUT_CYCLES` = 0, slave withholds ack for 1000 cycles: no error; grant holds until ack.
